// File: rtl/clint_pkg.sv
// -----------------------------------------------------------------------------
// clint_pkg
// Shared definitions for the multi-hart core-local interruptor (clint_mh):
// the standard CLINT register offsets, the mtimecmp reset value, the 64-bit
// time type and the address-decode selector used by the top level.
// -----------------------------------------------------------------------------
package clint_pkg;

    typedef logic [63:0] mtime_t;

    // Byte offsets of the register groups
    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_LO      = 16'hBFF8;
    localparam logic [15:0] MTIME_HI      = 16'hBFFC;

    // mtimecmp resets to the largest value so no timer irq fires out of reset
    localparam mtime_t MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // Which register a bus address selects
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_MTIME_LO,
        SEL_MTIME_HI
    } sel_e;

endpackage

// File: rtl/clint_timebase.sv
// -----------------------------------------------------------------------------
// clint_timebase
// Prescaler plus the shared 64-bit mtime counter.
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_we_lo, i_we_hi : bus write strobes for the mtime low/high word
//   i_wdata          : bus write data
//   o_tick           : prescaler terminal count (mtime increments this cycle)
//   o_mtime          : current mtime
//   o_mtime_next     : value mtime takes at the next clock edge
// A bus write to one half wins over a same-cycle tick; the other half is held
// and no increment happens in that cycle.
// -----------------------------------------------------------------------------
module clint_timebase
    import clint_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_we_lo,
    input  logic        i_we_hi,
    input  logic [31:0] i_wdata,
    output logic        o_tick,
    output mtime_t      o_mtime,
    output mtime_t      o_mtime_next
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] r_prescale;
    mtime_t           r_mtime;
    mtime_t           w_mtime_next;
    logic             w_tick;

    // With TICK_DIV == 1 the counter is stuck at 0 and this is always true.
    assign w_tick = (r_prescale == CNT_W'(TICK_DIV - 1));

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        w_mtime_next = r_mtime;
        if (i_we_lo) begin
            w_mtime_next[31:0] = i_wdata;
        end else if (i_we_hi) begin
            w_mtime_next[63:32] = i_wdata;
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prescale <= '0;
            r_mtime    <= '0;
        end else begin
            r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
            r_mtime    <= w_mtime_next;
        end
    end

    assign o_tick       = w_tick;
    assign o_mtime      = r_mtime;
    assign o_mtime_next = w_mtime_next;

endmodule

// File: rtl/clint_mh.sv
// -----------------------------------------------------------------------------
// clint_mh
// Multi-hart core-local interruptor: one shared mtime, per-hart msip and
// mtimecmp, reachable through a 32-bit register port with a one-cycle response.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i, we_i   : access request (always accepted), 1 = write
//   addr_i        : byte address (bits [1:0] ignored), wdata_i: write data
//   rvalid_o      : response strobe one cycle after every request
//   rdata_o       : read data (0 for writes and unmapped accesses)
//   err_o         : unmapped access, valid with rvalid_o
//   mtime_o       : current mtime
//   timer_irq_o   : per hart, mtime >= mtimecmp[h]
//   soft_irq_o    : per hart, msip[h]
// -----------------------------------------------------------------------------
module clint_mh
    import clint_pkg::*;
#(
    parameter int NUM_HARTS = 2,
    parameter int TICK_DIV  = 1,
    parameter int ADDR_W    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_i,
    input  logic                 we_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    output logic                 rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 err_o,
    output logic [63:0]          mtime_o,
    output logic [NUM_HARTS-1:0] timer_irq_o,
    output logic [NUM_HARTS-1:0] soft_irq_o
);

    localparam int HART_W = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

    // Per-hart state
    logic [NUM_HARTS-1:0] r_msip;
    mtime_t               r_mtimecmp [NUM_HARTS];
    logic [NUM_HARTS-1:0] r_timer_irq;

    // Response register
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic        r_err;

    // Decode and next-state
    logic [ADDR_W-1:0]    w_word;
    sel_e                 w_sel;
    logic [HART_W-1:0]    w_hart;
    logic                 w_wr;
    logic                 w_rd;
    logic [31:0]          w_rdata;
    logic [NUM_HARTS-1:0] w_msip_next;
    mtime_t               w_cmp_next [NUM_HARTS];
    logic [NUM_HARTS-1:0] w_timer_irq_next;
    mtime_t               w_mtime;
    mtime_t               w_mtime_next;
    logic                 w_tick;
    logic                 w_unused;

    assign w_wr   = req_i & we_i;
    assign w_rd   = req_i & ~we_i;
    assign w_word = {addr_i[ADDR_W-1:2], 2'b00};

    // Address decode: an explicit match per hart, so hart indices beyond
    // NUM_HARTS and every other offset fall through to SEL_NONE.
    always_comb begin
        w_sel  = SEL_NONE;
        w_hart = '0;
        for (int h = 0; h < NUM_HARTS; h++) begin
            if (w_word == ADDR_W'(MSIP_BASE) + ADDR_W'(4 * h)) begin
                w_sel  = SEL_MSIP;
                w_hart = HART_W'(h);
            end
            if (w_word == ADDR_W'(MTIMECMP_BASE) + ADDR_W'(8 * h)) begin
                w_sel  = SEL_CMP_LO;
                w_hart = HART_W'(h);
            end
            if (w_word == ADDR_W'(MTIMECMP_BASE) + ADDR_W'(8 * h + 4)) begin
                w_sel  = SEL_CMP_HI;
                w_hart = HART_W'(h);
            end
        end
        if (w_word == ADDR_W'(MTIME_LO)) begin
            w_sel = SEL_MTIME_LO;
        end
        if (w_word == ADDR_W'(MTIME_HI)) begin
            w_sel = SEL_MTIME_HI;
        end
    end

    clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .i_clk        (clk_i),
        .i_rst        (rst_i),
        .i_we_lo      (w_wr && (w_sel == SEL_MTIME_LO)),
        .i_we_hi      (w_wr && (w_sel == SEL_MTIME_HI)),
        .i_wdata      (wdata_i),
        .o_tick       (w_tick),
        .o_mtime      (w_mtime),
        .o_mtime_next (w_mtime_next)
    );

    // Per-hart next values and the irq compare against the post-update state,
    // so timer_irq_o rises in the same cycle mtime_o first reaches mtimecmp.
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            w_msip_next[h] = r_msip[h];
            w_cmp_next[h]  = r_mtimecmp[h];
            if (w_wr && (w_hart == HART_W'(h))) begin
                case (w_sel)
                    SEL_MSIP:   w_msip_next[h]       = wdata_i[0];
                    SEL_CMP_LO: w_cmp_next[h][31:0]  = wdata_i;
                    SEL_CMP_HI: w_cmp_next[h][63:32] = wdata_i;
                    default:    ;
                endcase
            end
            w_timer_irq_next[h] = (w_mtime_next >= w_cmp_next[h]);
        end
    end

    // Read mux returns pre-update values.
    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (w_sel)
                SEL_MSIP:     w_rdata = {31'd0, r_msip[w_hart]};
                SEL_CMP_LO:   w_rdata = r_mtimecmp[w_hart][31:0];
                SEL_CMP_HI:   w_rdata = r_mtimecmp[w_hart][63:32];
                SEL_MTIME_LO: w_rdata = w_mtime[31:0];
                SEL_MTIME_HI: w_rdata = w_mtime[63:32];
                default:      w_rdata = '0;
            endcase
        end
    end

    // NOTE: the small per-hart register arrays are reset explicitly because
    // their reset values are architecturally visible (mtimecmp = all ones).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_msip      <= '0;
            r_timer_irq <= '0;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_mtimecmp[h] <= MTIMECMP_RST;
            end
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_msip      <= w_msip_next;
            r_timer_irq <= w_timer_irq_next;
            for (int h = 0; h < NUM_HARTS; h++) begin
                r_mtimecmp[h] <= w_cmp_next[h];
            end
            r_rvalid    <= req_i;
            r_rdata     <= w_rdata;
            r_err       <= req_i && (w_sel == SEL_NONE);
        end
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign mtime_o     = w_mtime;
    assign timer_irq_o = r_timer_irq;
    assign soft_irq_o  = r_msip;

    // Byte-lane bits and the tick strobe are intentionally unused here.
    assign w_unused = ^{addr_i[1:0], w_tick};

endmodule

// File: tb/tb_clint_mh.sv
// -----------------------------------------------------------------------------
// tb_clint_mh
// Self-checking bench for clint_mh (NUM_HARTS=2, TICK_DIV=4, ADDR_W=16).
// A register-level model tracks mtime, the prescale phase, msip and mtimecmp
// and predicts every output each cycle; directed sequences add literal checks.
// -----------------------------------------------------------------------------
module tb_clint_mh;

    localparam int NH = 2;
    localparam int TD = 4;
    localparam int AW = 16;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [31:0]   wdata_i;
    logic          rvalid_o;
    logic [31:0]   rdata_o;
    logic          err_o;
    logic [63:0]   mtime_o;
    logic [NH-1:0] timer_irq_o;
    logic [NH-1:0] soft_irq_o;

    clint_mh #(
        .NUM_HARTS (NH),
        .TICK_DIV  (TD),
        .ADDR_W    (AW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .mtime_o     (mtime_o),
        .timer_irq_o (timer_irq_o),
        .soft_irq_o  (soft_irq_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // Register kinds: 0 unmapped, 1 msip, 2 cmp lo, 3 cmp hi, 4 mtime lo, 5 mtime hi
    function automatic int classify(input logic [15:0] a_in, output int h);
        int a;
        a = int'(a_in) & ~3;
        h = 0;
        if (a < 4 * NH) begin
            h = a / 4;
            return 1;
        end
        if (a >= 'h4000 && a < 'h4000 + 8 * NH) begin
            h = (a - 'h4000) / 8;
            return (((a - 'h4000) % 8) == 0) ? 2 : 3;
        end
        if (a == 'hBFF8) return 4;
        if (a == 'hBFFC) return 5;
        return 0;
    endfunction

    logic [63:0] m_mtime;
    int          m_pre;
    logic [NH-1:0] m_msip;
    logic [63:0] m_cmp [NH];
    logic        e_rvalid;
    logic        e_err;
    logic [31:0] e_rdata;
    logic [NH-1:0] e_tirq;
    bit          model_live = 1'b0;

    always @(posedge clk_i) begin
        int          kind;
        int          h;
        logic [31:0] rv;
        logic [63:0] nxt;
        bit          tick;
        if (rst_i) begin
            m_mtime  = 64'd0;
            m_pre    = 0;
            m_msip   = '0;
            for (int i = 0; i < NH; i++) m_cmp[i] = 64'hFFFF_FFFF_FFFF_FFFF;
            e_rvalid = 1'b0;
            e_err    = 1'b0;
            e_rdata  = 32'd0;
            e_tirq   = '0;
        end else begin
            kind = classify(addr_i, h);
            rv = 32'd0;
            if (req_i && !we_i) begin
                case (kind)
                    1: rv = {31'd0, m_msip[h]};
                    2: rv = m_cmp[h][31:0];
                    3: rv = m_cmp[h][63:32];
                    4: rv = m_mtime[31:0];
                    5: rv = m_mtime[63:32];
                    default: rv = 32'd0;
                endcase
            end
            e_rvalid = req_i;
            e_err    = req_i && (kind == 0);
            e_rdata  = rv;
            tick  = (m_pre == TD - 1);
            m_pre = tick ? 0 : m_pre + 1;
            nxt   = tick ? m_mtime + 64'd1 : m_mtime;
            if (req_i && we_i) begin
                case (kind)
                    1: m_msip[h] = wdata_i[0];
                    2: m_cmp[h]  = {m_cmp[h][63:32], wdata_i};
                    3: m_cmp[h]  = {wdata_i, m_cmp[h][31:0]};
                    4: nxt       = {m_mtime[63:32], wdata_i};
                    5: nxt       = {wdata_i, m_mtime[31:0]};
                    default: ;
                endcase
            end
            m_mtime = nxt;
            for (int i = 0; i < NH; i++) e_tirq[i] = (m_mtime >= m_cmp[i]);
        end
        model_live = 1'b1;
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk_i) begin
        if (model_live) begin
            check("cyc_rvalid", rvalid_o, e_rvalid);
            check("cyc_rdata", rdata_o, e_rdata);
            check("cyc_err", err_o, e_err);
            check("cyc_mtime", mtime_o, m_mtime);
            check("cyc_timer_irq", timer_irq_o, e_tirq);
            check("cyc_soft_irq", soft_irq_o, m_msip);
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic we, input logic [15:0] addr, input logic [31:0] data);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = data;
        @(negedge clk_i);
        req_i   = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic wait_mtime_change(input string name);
        logic [63:0] prev;
        int n;
        prev = mtime_o;
        n = 0;
        while (mtime_o == prev && n < 8) begin
            @(negedge clk_i);
            n++;
        end
        check(name, mtime_o != prev, 1'b1);
    endtask

    initial begin
        int n;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk_i);

        // Reset state
        check("rst_rvalid", rvalid_o, 1'b0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_err", err_o, 1'b0);
        check("rst_mtime", mtime_o, 64'd0);
        check("rst_timer_irq", timer_irq_o, 2'b00);
        check("rst_soft_irq", soft_irq_o, 2'b00);
        rst_i = 1'b0;

        bus(1'b0, 16'h4004, 32'd0);
        check("rd_cmp0_hi_rvalid", rvalid_o, 1'b1);
        check("rd_cmp0_hi_data", rdata_o, 32'hFFFF_FFFF);
        check("rd_cmp0_hi_err", err_o, 1'b0);

        // Timer irq for hart 0 at mtime == 10
        bus(1'b1, 16'h4000, 32'd10);
        bus(1'b1, 16'h4004, 32'd0);
        check("tirq0_before", timer_irq_o[0], 1'b0);
        n = 0;
        while (!timer_irq_o[0] && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("tirq0_rise_in_time", n < 200, 1'b1);
        check("tirq0_rise_mtime", mtime_o, 64'd10);
        check("tirq1_quiet", timer_irq_o[1], 1'b0);

        // Software irq for hart 1; only bit 0 of msip is writable
        bus(1'b1, 16'h0004, 32'd1);
        check("sirq1_set", soft_irq_o, 2'b10);
        bus(1'b1, 16'h0004, 32'h2);
        check("sirq1_clr", soft_irq_o, 2'b00);
        bus(1'b0, 16'h0004, 32'd0);
        check("rd_msip1", rdata_o, 32'd0);

        // Carry from low to high word
        bus(1'b1, 16'hBFFC, 32'd0);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
        check("mtime_lo_ones", mtime_o, 64'h0000_0000_FFFF_FFFF);
        wait_mtime_change("carry_tick_seen");
        check("mtime_carry", mtime_o, 64'h0000_0001_0000_0000);

        // Full 64-bit wrap
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
        check("mtime_all_ones", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        check("tirq0_at_max", timer_irq_o[0], 1'b1);
        wait_mtime_change("wrap_tick_seen");
        check("mtime_wrap", mtime_o, 64'd0);
        check("tirq0_after_wrap", timer_irq_o[0], 1'b0);

        // Write low word in the exact tick cycle
        wait_mtime_change("align_tick_seen");
        repeat (3) @(negedge clk_i);
        bus(1'b1, 16'hBFF8, 32'd100);
        check("mtime_write_wins", mtime_o, 64'd100);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("mtime_hold_100", mtime_o, 64'd100);
        end
        @(negedge clk_i);
        check("mtime_next_101", mtime_o, 64'd101);
        check("mtime_hi_kept", mtime_o[63:32], 32'd0);

        // Raising mtimecmp above mtime drops the level irq next cycle
        check("tirq0_high", timer_irq_o[0], 1'b1);
        bus(1'b1, 16'h4004, 32'd1);
        check("tirq0_dropped", timer_irq_o[0], 1'b0);

        // Unmapped accesses
        bus(1'b0, 16'h8000, 32'd0);
        check("unmap_8000_err", err_o, 1'b1);
        check("unmap_8000_data", rdata_o, 32'd0);
        bus(1'b0, 16'h0008, 32'd0);
        check("unmap_msip2_err", err_o, 1'b1);
        bus(1'b1, 16'h4010, 32'd5);
        check("unmap_wr_err", err_o, 1'b1);
        bus(1'b0, 16'h4000, 32'd0);
        check("cmp0_lo_kept", rdata_o, 32'd10);
        check("cmp0_lo_kept_err", err_o, 1'b0);

        // Back-to-back reads of mtime and hart-1 mtimecmp (model-checked)
        bus(1'b0, 16'hBFF8, 32'd0);
        bus(1'b0, 16'hBFFC, 32'd0);
        bus(1'b0, 16'h400C, 32'd0);
        check("b2b_cmp1_hi", rdata_o, 32'hFFFF_FFFF);

        // Reset together with a request: no response follows
        rst_i = 1'b1; req_i = 1'b1; we_i = 1'b0; addr_i = 16'h4004;
        @(negedge clk_i);
        req_i = 1'b0;
        check("rst_drop_rvalid", rvalid_o, 1'b0);
        check("rst_drop_mtime", mtime_o, 64'd0);
        rst_i = 1'b0;
        bus(1'b0, 16'h4004, 32'd0);
        check("rst_cmp0_hi", rdata_o, 32'hFFFF_FFFF);

        repeat (5) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
